// File: rtl/siaminer_work_sched.sv
// rtl/siaminer_work_sched.sv - broadcasts work to NUM_CORES hash cores, splits the nonce space into rounds, arbitrates finds.
// Optional macro SIAMINER_SCHED_EXHAUST_RPT_EN: report full-space exhaustion as a result instead of returning silently to IDLE.
module siaminer_work_sched #(
    parameter int NUM_CORES  = 4,
    parameter int RANGE_LOG2 = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      work_valid,
    output logic                      work_ready,
    input  logic [639:0]              work,
    input  logic [31:0]               target,
    output logic [NUM_CORES-1:0]      core_load,
    output logic [639:0]              core_work,
    output logic [31:0]               core_target,
    output logic [NUM_CORES*32-1:0]   core_base,
    output logic [NUM_CORES-1:0]      core_abort,
    input  logic [NUM_CORES-1:0]      core_found,
    input  logic [NUM_CORES-1:0]      core_done,
    input  logic [NUM_CORES*32-1:0]   core_nonce,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [31:0]               res_nonce,
    output logic                      res_exhausted
);

    localparam int CORE_LOG2 = $clog2(NUM_CORES);
    localparam int SHIFT     = RANGE_LOG2 + CORE_LOG2;
    localparam int ROUND_W   = 33 - SHIFT;
    localparam logic [ROUND_W-1:0] ROUND_LIMIT = ROUND_W'(1) << (ROUND_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_REPORT} state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [639:0]              r_work;
    logic [31:0]               r_target;
    logic [31:0]               r_start;
    logic [ROUND_W-1:0]        r_round;
    logic [NUM_CORES-1:0]      r_done;
    logic [NUM_CORES-1:0]      r_abort;
    logic [NUM_CORES*32-1:0]   r_base;
    logic                      r_res_valid;
    logic [31:0]               r_res_nonce;

    logic                      w_accept;
    logic                      w_found;
    logic                      w_advance;
    logic                      w_exhaust;
    logic                      w_done_all;
    logic [31:0]               w_found_nonce;
    logic [31:0]               w_work_start;
    logic [ROUND_W-1:0]        w_round_inc;
    logic [31:0]               w_base_start;
    logic [ROUND_W-1:0]        w_base_round;
    logic [31:0]               w_round_off;
    logic [NUM_CORES*32-1:0]   w_base_next;

    // Nonce field is stored little-endian in the header.
    assign w_work_start = {work[263:256], work[271:264], work[279:272], work[287:280]};
    assign w_round_inc  = r_round + 1'b1;
    assign w_done_all   = &(r_done | core_done);

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_found       = 1'b0;
        w_advance     = 1'b0;
        w_exhaust     = 1'b0;
        w_found_nonce = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_found[i]) begin
                w_found_nonce = core_nonce[i*32 +: 32];
            end
        end
        case (r_state)
            S_IDLE: begin
                if (work_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (work_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_LOAD;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // Preemption wins: any find/done in this cycle belongs to the old work.
                if (work_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_LOAD;
                end else if (|core_found) begin
                    w_found      = 1'b1;
                    w_state_next = S_REPORT;
                end else if (w_done_all) begin
                    if (w_round_inc == ROUND_LIMIT) begin
                        w_exhaust = 1'b1;
`ifdef SIAMINER_SCHED_EXHAUST_RPT_EN
                        w_state_next = S_REPORT;
`else
                        w_state_next = S_IDLE;
`endif
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = S_LOAD;
                    end
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_base_start = w_accept ? w_work_start : r_start;
    assign w_base_round = w_accept ? '0 : w_round_inc;
    assign w_round_off  = 32'(w_base_round) << SHIFT;

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_base
        assign w_base_next[gi*32 +: 32] = w_base_start + w_round_off + (32'(gi) << RANGE_LOG2);
    end

`ifdef SIAMINER_SCHED_EXHAUST_RPT_EN
    logic r_res_exh;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_res_exh <= 1'b0;
        end else if (w_found) begin
            r_res_exh <= 1'b0;
        end else if (w_exhaust) begin
            r_res_exh <= 1'b1;
        end else if (r_state == S_REPORT && res_ready) begin
            r_res_exh <= 1'b0;
        end
    end

    assign res_exhausted = r_res_exh;
`else
    assign res_exhausted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_work      <= '0;
            r_target    <= '0;
            r_start     <= '0;
            r_round     <= '0;
            r_done      <= '0;
            r_abort     <= '0;
            r_base      <= '0;
            r_res_valid <= 1'b0;
            r_res_nonce <= '0;
        end else begin
            r_state <= w_state_next;
            r_abort <= '0;
            if (w_accept) begin
                r_work   <= work;
                r_target <= target;
                r_start  <= w_work_start;
                r_round  <= '0;
                r_done   <= '0;
            end else if (w_advance) begin
                r_round <= w_round_inc;
                r_done  <= '0;
            end else if (r_state == S_RUN) begin
                r_done <= r_done | core_done;
            end
            if (w_accept || w_advance) begin
                r_base <= w_base_next;
            end
            if (w_found) begin
                r_res_valid <= 1'b1;
                r_res_nonce <= w_found_nonce;
                r_abort     <= '1;
            end
`ifdef SIAMINER_SCHED_EXHAUST_RPT_EN
            if (w_exhaust) begin
                r_res_valid <= 1'b1;
                r_res_nonce <= r_start;
            end
`endif
            if (r_state == S_REPORT && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign work_ready  = (r_state != S_REPORT);
    assign core_load   = (r_state == S_LOAD) ? '1 : '0;
    assign core_work   = r_work;
    assign core_target = r_target;
    assign core_base   = r_base;
    assign core_abort  = r_abort;
    assign res_valid   = r_res_valid;
    assign res_nonce   = r_res_nonce;

endmodule

// File: tb/tb_siaminer_work_sched.sv
// tb/tb_siaminer_work_sched.sv - directed self-checking bench for siaminer_work_sched (default and RANGE_LOG2=30 instances).
module tb_siaminer_work_sched;

    logic           clk = 1'b0;
    logic           rst;

    logic           work_valid;
    logic           work_ready;
    logic [639:0]   work;
    logic [31:0]    target;
    logic [3:0]     core_load;
    logic [639:0]   core_work;
    logic [31:0]    core_target;
    logic [127:0]   core_base;
    logic [3:0]     core_abort;
    logic [3:0]     core_found;
    logic [3:0]     core_done;
    logic [127:0]   core_nonce;
    logic           res_valid;
    logic           res_ready;
    logic [31:0]    res_nonce;
    logic           res_exhausted;

    logic           w2_valid;
    logic           w2_ready;
    logic [639:0]   w2_work;
    logic [3:0]     c2_load;
    logic [639:0]   c2_work;
    logic [31:0]    c2_target;
    logic [127:0]   c2_base;
    logic [3:0]     c2_abort;
    logic [3:0]     c2_found;
    logic [3:0]     c2_done;
    logic [127:0]   c2_nonce;
    logic           r2_valid;
    logic           r2_ready;
    logic [31:0]    r2_nonce;
    logic           r2_exh;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    siaminer_work_sched #(.NUM_CORES(4), .RANGE_LOG2(8)) u_dut (
        .clk(clk), .rst(rst),
        .work_valid(work_valid), .work_ready(work_ready), .work(work), .target(target),
        .core_load(core_load), .core_work(core_work), .core_target(core_target),
        .core_base(core_base), .core_abort(core_abort),
        .core_found(core_found), .core_done(core_done), .core_nonce(core_nonce),
        .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce),
        .res_exhausted(res_exhausted)
    );

    siaminer_work_sched #(.NUM_CORES(4), .RANGE_LOG2(30)) u_dut_wide (
        .clk(clk), .rst(rst),
        .work_valid(w2_valid), .work_ready(w2_ready), .work(w2_work), .target(32'h0000_FFFF),
        .core_load(c2_load), .core_work(c2_work), .core_target(c2_target),
        .core_base(c2_base), .core_abort(c2_abort),
        .core_found(c2_found), .core_done(c2_done), .core_nonce(c2_nonce),
        .res_valid(r2_valid), .res_ready(r2_ready), .res_nonce(r2_nonce),
        .res_exhausted(r2_exh)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [639:0] mk_work(input logic [31:0] start);
        logic [639:0] w;
        w = {20{32'hA5C3_0F1E}};
        w[287:256] = {start[7:0], start[15:8], start[23:16], start[31:24]};
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bases(input string tag, input logic [127:0] got,
                               input logic [31:0] b0, input logic [31:0] b1,
                               input logic [31:0] b2, input logic [31:0] b3);
        check({tag, "_b0"}, 64'(got[31:0]),   64'(b0));
        check({tag, "_b1"}, 64'(got[63:32]),  64'(b1));
        check({tag, "_b2"}, 64'(got[95:64]),  64'(b2));
        check({tag, "_b3"}, 64'(got[127:96]), 64'(b3));
    endtask

    initial begin
        logic [31:0] held_nonce;
        rst = 1'b0;
        work_valid = 1'b0; work = '0; target = '0;
        core_found = '0; core_done = '0; core_nonce = '0; res_ready = 1'b0;
        w2_valid = 1'b0; w2_work = '0; c2_found = '0; c2_done = '0; c2_nonce = '0; r2_ready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_nonce", 64'(res_nonce), 64'd0);
        check("rst_res_exh",   64'(res_exhausted), 64'd0);
        check("rst_load",      64'(core_load), 64'd0);
        check("rst_abort",     64'(core_abort), 64'd0);
        check("rst_target",    64'(core_target), 64'd0);
        check("rst_work",      core_work[63:0], 64'd0);
        check_bases("rst", core_base, 32'h0, 32'h0, 32'h0, 32'h0);
        rst = 1'b1;
        tick();
        check("idle_ready", 64'(work_ready), 64'd1);
        check("idle_load",  64'(core_load), 64'd0);

        // Load with start 0x12345600
        work = mk_work(32'h1234_5600); target = 32'hDEAD_BEEF; work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        check("t2_load", 64'(core_load), 64'hF);
        check_bases("t2", core_base, 32'h1234_5600, 32'h1234_5700, 32'h1234_5800, 32'h1234_5900);
        check("t2_target", 64'(core_target), 64'hDEAD_BEEF);
        check("t2_work_nonce", 64'(core_work[287:256]), 64'h0056_3412);
        tick();
        check("t2_load_pulse", 64'(core_load), 64'd0);

        // Two simultaneous finds: lowest index wins
        core_found = 4'b0110;
        core_nonce = {32'h0, 32'h1234_5877, 32'h1234_57AA, 32'h0};
        tick();
        core_found = '0;
        check("t3_res_valid", 64'(res_valid), 64'd1);
        check("t3_res_nonce", 64'(res_nonce), 64'h1234_57AA);
        check("t3_abort",     64'(core_abort), 64'hF);
        check("t3_ready",     64'(work_ready), 64'd0);
        held_nonce = res_nonce;

        // Back-pressure in REPORT
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t6_hold_valid", 64'(res_valid), 64'd1);
            check("t6_hold_nonce", 64'(res_nonce), 64'h1234_57AA);
            check("t6_hold_ready", 64'(work_ready), 64'd0);
            check("t6_abort_once", 64'(core_abort), 64'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("t3_release_valid", 64'(res_valid), 64'd0);
        check("t3_release_ready", 64'(work_ready), 64'd1);
        check("t3_nonce_kept",    64'(res_nonce), 64'(held_nonce));

        // Round advance with wrap past 2^32
        work = mk_work(32'hFFFF_FE00); work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        check_bases("t4_r0", core_base, 32'hFFFF_FE00, 32'hFFFF_FF00, 32'h0000_0000, 32'h0000_0100);
        tick();
        for (int i = 0; i < 4; i++) begin
            core_done = 4'(1 << i);
            tick();
            core_done = '0;
            if (i < 3) begin
                check("t4_no_early_load", 64'(core_load), 64'd0);
                tick();
            end
        end
        check("t4_reload", 64'(core_load), 64'hF);
        check_bases("t4_r1", core_base, 32'h0000_0200, 32'h0000_0300, 32'h0000_0400, 32'h0000_0500);
        tick();

        // Find from a core already flagged done is honoured; found beats done
        core_done = 4'b0001;
        tick();
        core_done = 4'b0001; core_found = 4'b0001; core_nonce = {96'h0, 32'h0000_0211};
        tick();
        core_done = '0; core_found = '0;
        check("t4_found_after_done", 64'(res_valid), 64'd1);
        check("t4_found_nonce", 64'(res_nonce), 64'h0000_0211);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Preemption discards a simultaneous find
        work = mk_work(32'h0100_0000); work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        tick();
        work = mk_work(32'hAABB_CC00); work_valid = 1'b1;
        core_found = 4'b0001; core_nonce = {96'h0, 32'h0100_0042};
        tick();
        work_valid = 1'b0; core_found = '0;
        check("t5_no_result", 64'(res_valid), 64'd0);
        check("t5_no_abort",  64'(core_abort), 64'd0);
        check("t5_load",      64'(core_load), 64'hF);
        check("t5_base0",     64'(core_base[31:0]), 64'hAABB_CC00);
        tick();
        check("t5_still_none", 64'(res_valid), 64'd0);

        // Reset in REPORT drops the result without abort
        core_found = 4'b1000; core_nonce = {32'hAABB_CD10, 96'h0};
        tick();
        core_found = '0;
        check("t7_report", 64'(res_nonce), 64'hAABB_CD10);
        rst = 1'b0;
        tick();
        check("t7_rst_valid", 64'(res_valid), 64'd0);
        check("t7_rst_abort", 64'(core_abort), 64'd0);
        check("t7_rst_base3", 64'(core_base[127:96]), 64'd0);
        rst = 1'b1;
        tick();

        // Full-space exhaustion on the RANGE_LOG2=30 instance
        w2_work = mk_work(32'h1234_5600); w2_valid = 1'b1;
        tick();
        w2_valid = 1'b0;
        check_bases("t6w", c2_base, 32'h1234_5600, 32'h5234_5600, 32'h9234_5600, 32'hD234_5600);
        tick();
        c2_done = 4'b1111;
        tick();
        c2_done = '0;
        check("t6w_no_reload", 64'(c2_load), 64'd0);
`ifdef SIAMINER_SCHED_EXHAUST_RPT_EN
        check("t6w_valid", 64'(r2_valid), 64'd1);
        check("t6w_exh",   64'(r2_exh), 64'd1);
        check("t6w_nonce", 64'(r2_nonce), 64'h1234_5600);
        check("t6w_ready", 64'(w2_ready), 64'd0);
        r2_ready = 1'b1;
        tick();
        r2_ready = 1'b0;
        check("t6w_exh_clear", 64'(r2_exh), 64'd0);
`else
        check("t6w_valid", 64'(r2_valid), 64'd0);
        check("t6w_exh",   64'(r2_exh), 64'd0);
        check("t6w_ready", 64'(w2_ready), 64'd1);
`endif
        check("t6w_final_valid", 64'(r2_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
